sync_fifo_lvl: RTL



---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem.sv | 31 +++
 rtl/sync_fifo_lvl.sv | 106 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for sync_fifo_lvl: pointer/count width functions and the
// parameter legality rule checked at elaboration by the top.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Count must represent 0..depth inclusive, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_legal(input int depth, input int af_level,
                                      input int ae_level);
    return (depth >= 2) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: MEM_DEPTH x DATA_WIDTH array, one write port and one
// registered read port. The array itself is never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [ptr_width(MEM_DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              rd_en,
  input  logic [ptr_width(MEM_DEPTH)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]             rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; it holds when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty levels and
// any depth >= 2. Optional sticky ovf/udf flags under SYNC_FIFO_LVL_ERR_EN.
module sync_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4,
  parameter int AF_LEVEL   = MEM_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef SYNC_FIFO_LVL_ERR_EN
  input  logic                            err_clr,
  output logic                            ovf,
  output logic                            udf,
`endif
  input  logic                            we,
  input  logic [DATA_WIDTH-1:0]           wrdata,
  output logic                            full,
  output logic                            almost_full,
  input  logic                            re,
  output logic [DATA_WIDTH-1:0]           rddata,
  output logic                            empty,
  output logic                            almost_empty,
  output logic [cnt_width(MEM_DEPTH)-1:0] count
);

  localparam int PTR_W = ptr_width(MEM_DEPTH);
  localparam int CNT_W = cnt_width(MEM_DEPTH);

  if (!params_legal(MEM_DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_lvl: illegal MEM_DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_ok, rd_ok;

  assign wr_ok = we && !full;
  assign rd_ok = re && !empty;

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok)      count_nxt = count + CNT_W'(1);
    else if (rd_ok && !wr_ok) count_nxt = count - CNT_W'(1);
  end

  // Explicit wrap so non-power-of-two depths work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PTR_W'(MEM_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= (rd_ptr == PTR_W'(MEM_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // Flags are registered from the next count so they always match count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == CNT_W'(MEM_DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CNT_W'(AF_LEVEL));
      almost_empty <= (count_nxt <= CNT_W'(AE_LEVEL));
    end
  end

`ifdef SYNC_FIFO_LVL_ERR_EN
  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (we && full)     ovf <= 1'b1;
      else if (err_clr)   ovf <= 1'b0;
      if (re && empty)    udf <= 1'b1;
      else if (err_clr)   udf <= 1'b0;
    end
  end
`endif

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (wrdata),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (rddata)
  );

endmodule
